// File: rtl/photobooth_pkg.sv
// Shared types and constants for the photobooth session controller.
package photobooth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_FLASH     = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_REVIEW    = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_t;

    typedef enum logic [2:0] {
        DISP_START  = 3'd0,
        DISP_LIVE   = 3'd1,
        DISP_FLASH  = 3'd2,
        DISP_REVIEW = 3'd3,
        DISP_DONE   = 3'd4
    } disp_sel_t;

    // Pixel value the display mux substitutes while the flash is shown.
    localparam logic [11:0] WHITE_PIXEL = 12'hFFF;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Pixel-source selection shown for each sequencer state.
    function automatic disp_sel_t disp_for_state(input seq_state_t s);
        case (s)
            ST_IDLE:      return DISP_START;
            ST_COUNTDOWN: return DISP_LIVE;
            ST_FLASH:     return DISP_FLASH;
            ST_CAPTURE:   return DISP_FLASH;
            ST_REVIEW:    return DISP_REVIEW;
            ST_DONE:      return DISP_DONE;
            default:      return DISP_START;
        endcase
    endfunction

endpackage

// File: rtl/photobooth_frame_timer.sv
// frame_timer: counts tick pulses and emits a one-cycle done on the tick that
// reaches the terminal count, then wraps to zero. clear has priority over tick.
module frame_timer #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count and terminal-tick detection.
    always_comb begin
        done    = 1'b0;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            if (count_q == (terminal - ONE)) begin
                done    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/photobooth_sequencer.sv
// photobooth_sequencer: session controller (start, countdown, flash, capture,
// review, repeat, done). All timing is in new_frame_in pulses.
// Optional capture watchdog: define PHOTOBOOTH_CAPTURE_TIMEOUT_EN.
module photobooth_sequencer
    import photobooth_pkg::*;
#(
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned COUNT_SECS     = 3,
    parameter int unsigned FLASH_FRAMES   = 4,
    parameter int unsigned REVIEW_FRAMES  = 120,
    parameter int unsigned NUM_SHOTS      = 4,
    parameter int unsigned TIMEOUT_FRAMES = 30
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_in,
    input  logic       armed_in,
    input  logic       new_frame_in,
    input  logic       capture_done_in,
    output logic [2:0] display_sel_out,
    output logic [3:0] countdown_out,
    output logic       capture_req_out,
    output logic [2:0] shot_idx_out,
    output logic       busy_out,
    output logic       session_done_out,
    output logic       err_out
);

    localparam int unsigned CNT_W =
        $clog2(max3(FRAMES_PER_SEC, REVIEW_FRAMES, TIMEOUT_FRAMES) + 1);

    seq_state_t       state_q, state_d;
    logic             entry_q, entry_d;
    logic [3:0]       countdown_q, countdown_d;
    logic             capture_req_q, capture_req_d;
    logic [2:0]       shot_idx_q, shot_idx_d;
    logic             busy_q, busy_d;
    logic             session_done_q, session_done_d;
    disp_sel_t        disp_q, disp_d;

    logic             timer_tick;
    logic             timer_done;
    logic [CNT_W-1:0] timer_term;

`ifdef PHOTOBOOTH_CAPTURE_TIMEOUT_EN
    logic             err_q, err_d;
`endif

    // Frame tick gating and per-state terminal count for the shared timer.
    always_comb begin
        timer_tick = new_frame_in && !((state_q == ST_CAPTURE) && capture_done_in);
        case (state_q)
            ST_COUNTDOWN: timer_term = CNT_W'(FRAMES_PER_SEC);
            ST_FLASH:     timer_term = CNT_W'(FLASH_FRAMES);
            ST_REVIEW:    timer_term = CNT_W'(REVIEW_FRAMES);
            ST_CAPTURE:   timer_term = CNT_W'(TIMEOUT_FRAMES);
            default:      timer_term = '1;
        endcase
    end

    // entry_q clears the timer in the first cycle of each state, so a frame
    // pulse arriving in that cycle is dropped.
    frame_timer #(
        .CNT_W(CNT_W)
    ) u_frame_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear    (entry_q),
        .tick     (timer_tick),
        .terminal (timer_term),
        .done     (timer_done)
    );

    // Next-state logic; registered outputs are derived from the next state.
    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        shot_idx_d  = shot_idx_q;
`ifdef PHOTOBOOTH_CAPTURE_TIMEOUT_EN
        err_d       = err_q;
`endif
        if ((state_q != ST_IDLE) && !armed_in) begin
            state_d    = ST_IDLE;
            shot_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_in && armed_in) begin
                        state_d    = ST_COUNTDOWN;
                        shot_idx_d = '0;
`ifdef PHOTOBOOTH_CAPTURE_TIMEOUT_EN
                        err_d      = 1'b0;
`endif
                    end
                end
                ST_COUNTDOWN: begin
                    if (timer_done) begin
                        if (countdown_q == 4'd1) begin
                            state_d = ST_FLASH;
                        end else begin
                            countdown_d = countdown_q - 4'd1;
                        end
                    end
                end
                ST_FLASH: begin
                    if (timer_done) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (capture_done_in) begin
                        state_d    = ST_REVIEW;
                        shot_idx_d = shot_idx_q + 3'd1;
                    end
`ifdef PHOTOBOOTH_CAPTURE_TIMEOUT_EN
                    else if (timer_done) begin
                        state_d    = ST_IDLE;
                        shot_idx_d = '0;
                        err_d      = 1'b1;
                    end
`endif
                end
                ST_REVIEW: begin
                    if (timer_done) begin
                        state_d = (shot_idx_q == 3'(NUM_SHOTS)) ? ST_DONE : ST_COUNTDOWN;
                    end
                end
                ST_DONE: begin
                    if (start_in) begin
                        state_d    = ST_IDLE;
                        shot_idx_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    shot_idx_d = '0;
                end
            endcase
        end

        // Countdown digit loads on any entry into COUNTDOWN and is zero elsewhere.
        if (state_d != ST_COUNTDOWN) begin
            countdown_d = '0;
        end else if (state_q != ST_COUNTDOWN) begin
            countdown_d = 4'(COUNT_SECS);
        end

        entry_d        = (state_d != state_q);
        capture_req_d  = (state_d == ST_CAPTURE);
        busy_d         = (state_d != ST_IDLE);
        session_done_d = (state_d == ST_DONE);
        disp_d         = disp_for_state(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= ST_IDLE;
            entry_q        <= 1'b0;
            countdown_q    <= '0;
            capture_req_q  <= 1'b0;
            shot_idx_q     <= '0;
            busy_q         <= 1'b0;
            session_done_q <= 1'b0;
            disp_q         <= DISP_START;
        end else begin
            state_q        <= state_d;
            entry_q        <= entry_d;
            countdown_q    <= countdown_d;
            capture_req_q  <= capture_req_d;
            shot_idx_q     <= shot_idx_d;
            busy_q         <= busy_d;
            session_done_q <= session_done_d;
            disp_q         <= disp_d;
        end
    end

`ifdef PHOTOBOOTH_CAPTURE_TIMEOUT_EN
    // Sticky capture-timeout flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

    assign display_sel_out  = disp_q;
    assign countdown_out    = countdown_q;
    assign capture_req_out  = capture_req_q;
    assign shot_idx_out     = shot_idx_q;
    assign busy_out         = busy_q;
    assign session_done_out = session_done_q;

endmodule
